// File: rtl/sram_arbiter_wb8.sv
// sram_arbiter_wb8 -- one-port arbiter for the 512 KiB x 8 asynchronous SRAM.
//
// The SRAM is shared by the VGA scan-out fetcher and the CPU's 8-bit Wishbone
// data bus. VGA reads always win and always see a one-cycle latency, so
// scan-out timing is independent of CPU traffic. The CPU takes whatever slots
// the VGA leaves free and is held off by a late ack.
//
// Ports:
//   I_clk, I_reset_n              shared clock, async active-low reset
//   I_vga_req, I_vga_adr          VGA read request pulse + address
//   O_vga_dat                     VGA read data (live in the VGA slot, held after)
//   I_wb_adr/dat/stb/we           Wishbone slave request side
//   O_wb_ack, O_wb_dat            Wishbone single-cycle ack + read data
//   O_sram_adr/dat/dat_oe         SRAM address, write data, pad output enable
//   I_sram_dat                    SRAM read data from the pads
//   O_sram_ce_n/oe_n/we_n         SRAM strobes, active low, all registered
module sram_arbiter_wb8 #(
    parameter int ADR_WIDTH = 19
) (
    input  logic                 I_clk,
    input  logic                 I_reset_n,
    input  logic                 I_vga_req,
    input  logic [ADR_WIDTH-1:0] I_vga_adr,
    output logic [7:0]           O_vga_dat,
    input  logic [ADR_WIDTH-1:0] I_wb_adr,
    input  logic [7:0]           I_wb_dat,
    input  logic                 I_wb_stb,
    input  logic                 I_wb_we,
    output logic                 O_wb_ack,
    output logic [7:0]           O_wb_dat,
    output logic [ADR_WIDTH-1:0] O_sram_adr,
    output logic [7:0]           O_sram_dat,
    output logic                 O_sram_dat_oe,
    input  logic [7:0]           I_sram_dat,
    output logic                 O_sram_ce_n,
    output logic                 O_sram_oe_n,
    output logic                 O_sram_we_n
);

    typedef enum logic [1:0] {IDLE, VGA_RD, CPU_RD, CPU_WR} slot_e;

    slot_e                slot_q, slot_d;
    logic                 ack_q, ack_d;
    logic [ADR_WIDTH-1:0] adr_q, adr_d;
    logic [7:0]           sdat_q, sdat_d;
    logic [7:0]           wb_dat_q, wb_dat_d;
    logic [7:0]           vga_dat_q, vga_dat_d;
    logic                 ce_n_q, ce_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 we_n_q, we_n_d;
    logic                 dat_oe_q, dat_oe_d;

    logic cpu_in_slot;
    logic cpu_pending;

    // A strobe still high during its own slot or ack cycle belongs to the
    // access already being served, so it must not start another one.
    assign cpu_in_slot = (slot_q == CPU_RD) || (slot_q == CPU_WR);
    assign cpu_pending = I_wb_stb && !ack_q && !cpu_in_slot;

    // State register
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) slot_q <= IDLE;
        else            slot_q <= slot_d;
    end

    // Next-slot decision: VGA first, then a pending CPU access
    always_comb begin
        slot_d = IDLE;
        if (I_vga_req)        slot_d = VGA_RD;
        else if (cpu_pending) slot_d = I_wb_we ? CPU_WR : CPU_RD;
    end

    // Outputs: pin values are decoded from the upcoming slot so they land in
    // flops on the same edge the slot starts.
    always_comb begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        dat_oe_d = 1'b0;
        adr_d    = adr_q;
        sdat_d   = sdat_q;
        case (slot_d)
            VGA_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                adr_d  = I_vga_adr;
            end
            CPU_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                adr_d  = I_wb_adr;
                sdat_d = I_wb_dat;
            end
            CPU_WR: begin
                ce_n_d   = 1'b0;
                we_n_d   = 1'b0;
                dat_oe_d = 1'b1;
                adr_d    = I_wb_adr;
                sdat_d   = I_wb_dat;
            end
            default: ;
        endcase
        // Read data is sampled at the end of the slot that drove the address
        ack_d     = cpu_in_slot;
        wb_dat_d  = (slot_q == CPU_RD) ? I_sram_dat : wb_dat_q;
        vga_dat_d = (slot_q == VGA_RD) ? I_sram_dat : vga_dat_q;
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            ack_q     <= 1'b0;
            adr_q     <= '0;
            sdat_q    <= 8'h00;
            wb_dat_q  <= 8'h00;
            vga_dat_q <= 8'h00;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dat_oe_q  <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            adr_q     <= adr_d;
            sdat_q    <= sdat_d;
            wb_dat_q  <= wb_dat_d;
            vga_dat_q <= vga_dat_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            dat_oe_q  <= dat_oe_d;
        end
    end

    // The VGA consumer gets the pad data in the slot itself, keeping its
    // latency at one cycle; the flop only holds it between fetches.
    assign O_vga_dat     = (slot_q == VGA_RD) ? I_sram_dat : vga_dat_q;
    assign O_wb_ack      = ack_q;
    assign O_wb_dat      = wb_dat_q;
    assign O_sram_adr    = adr_q;
    assign O_sram_dat    = sdat_q;
    assign O_sram_dat_oe = dat_oe_q;
    assign O_sram_ce_n   = ce_n_q;
    assign O_sram_oe_n   = oe_n_q;
    assign O_sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_arbiter_wb8.sv
// tb_sram_arbiter_wb8 -- scoreboard bench for sram_arbiter_wb8.
// Stimulus pushes expectations (data from a byte-level memory model, ack
// cycle derived from the VGA request history); a negedge monitor pops and
// compares whenever the DUT presents a VGA slot or a Wishbone ack.
module tb_sram_arbiter_wb8;
    localparam int AW = 19;

    logic          I_clk = 1'b0;
    logic          I_reset_n = 1'b1;
    logic          I_vga_req = 1'b0;
    logic [AW-1:0] I_vga_adr = '0;
    logic [7:0]    O_vga_dat;
    logic [AW-1:0] I_wb_adr = '0;
    logic [7:0]    I_wb_dat = 8'h00;
    logic          I_wb_stb = 1'b0;
    logic          I_wb_we = 1'b0;
    logic          O_wb_ack;
    logic [7:0]    O_wb_dat;
    logic [AW-1:0] O_sram_adr;
    logic [7:0]    O_sram_dat;
    logic          O_sram_dat_oe;
    logic [7:0]    I_sram_dat;
    logic          O_sram_ce_n, O_sram_oe_n, O_sram_we_n;

    sram_arbiter_wb8 #(.ADR_WIDTH(AW)) dut (
        .I_clk(I_clk), .I_reset_n(I_reset_n),
        .I_vga_req(I_vga_req), .I_vga_adr(I_vga_adr), .O_vga_dat(O_vga_dat),
        .I_wb_adr(I_wb_adr), .I_wb_dat(I_wb_dat), .I_wb_stb(I_wb_stb),
        .I_wb_we(I_wb_we), .O_wb_ack(O_wb_ack), .O_wb_dat(O_wb_dat),
        .O_sram_adr(O_sram_adr), .O_sram_dat(O_sram_dat),
        .O_sram_dat_oe(O_sram_dat_oe), .I_sram_dat(I_sram_dat),
        .O_sram_ce_n(O_sram_ce_n), .O_sram_oe_n(O_sram_oe_n),
        .O_sram_we_n(O_sram_we_n)
    );

    always #5 I_clk = ~I_clk;

    int cyc = 0;
    always @(posedge I_clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Background contents; a few fixed bytes for the directed cases
    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        case (a)
            19'h20000: return 8'hA5;
            19'h40000: return 8'h11;
            19'h40001: return 8'h22;
            default:   return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
        endcase
    endfunction

    // Asynchronous SRAM pad model: written at the edge ending a write cycle
    bit         sram_wr   [0:(1<<AW)-1];
    logic [7:0] sram_wdat [0:(1<<AW)-1];
    assign I_sram_dat = (!O_sram_ce_n && !O_sram_oe_n)
                      ? (sram_wr[O_sram_adr] ? sram_wdat[O_sram_adr] : init_byte(O_sram_adr))
                      : 8'hEE;
    always @(posedge I_clk) begin
        if (!O_sram_ce_n && !O_sram_we_n) begin
            sram_wr[O_sram_adr]   = 1'b1;
            sram_wdat[O_sram_adr] = O_sram_dat;
        end
    end

    // Reference memory: what the bus masters should observe
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_byte(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    endfunction

    typedef struct { logic [AW-1:0] adr; logic [7:0] dat; } vga_exp_t;
    typedef struct { int t; logic we; logic [AW-1:0] adr; logic [7:0] dat; } cpu_txn_t;
    vga_exp_t vga_q[$];
    cpu_txn_t cpu_q[$];
    bit       vga_hist[int];

    function automatic bit hist(input int c);
        return vga_hist.exists(c) ? vga_hist[c] : 1'b0;
    endfunction

    // ---------------- monitor ----------------
    bit            mon_en = 1'b0;
    logic [7:0]    vga_last = 8'h00;
    logic [3:0]    p_pins = 4'hF;
    logic [AW-1:0] p_adr = '0;
    logic [7:0]    p_sdat = 8'h00;
    vga_exp_t      m_ve;
    cpu_txn_t      m_ce;
    int            m_s;
    logic [3:0]    pins_now;

    always @(negedge I_clk) begin
        pins_now = {O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_dat_oe};
        if (!I_reset_n) begin
            vga_last = 8'h00;
        end else if (mon_en) begin
            if (hist(cyc - 1)) begin
                if (vga_q.size() == 0) chk(1'b0, "vga_queue", 0, 1);
                else begin
                    m_ve = vga_q.pop_front();
                    chk(O_sram_adr == m_ve.adr, "vga_adr", int'(O_sram_adr), int'(m_ve.adr));
                    chk(pins_now == 4'b0010, "vga_pins", int'(pins_now), 4'b0010);
                    chk(O_vga_dat == m_ve.dat, "vga_dat", int'(O_vga_dat), int'(m_ve.dat));
                    vga_last = m_ve.dat;
                end
            end else begin
                chk(O_vga_dat == vga_last, "vga_hold", int'(O_vga_dat), int'(vga_last));
            end
            if (O_wb_ack) begin
                if (cpu_q.size() == 0) chk(1'b0, "spurious_ack", 1, 0);
                else begin
                    m_ce = cpu_q.pop_front();
                    // Slot is the first cycle after issue not preceded by a VGA request
                    m_s = m_ce.t + 1;
                    while (hist(m_s - 1)) m_s++;
                    chk(cyc == m_s + 1, "ack_cycle", cyc, m_s + 1);
                    chk(p_adr == m_ce.adr, "cpu_adr", int'(p_adr), int'(m_ce.adr));
                    if (m_ce.we) begin
                        chk(p_pins == 4'b0101, "wr_pins", int'(p_pins), 4'b0101);
                        chk(p_sdat == m_ce.dat, "wr_sdat", int'(p_sdat), int'(m_ce.dat));
                        chk(sram_wr[m_ce.adr] && sram_wdat[m_ce.adr] == m_ce.dat, "wr_mem",
                            int'(sram_wdat[m_ce.adr]), int'(m_ce.dat));
                    end else begin
                        chk(p_pins == 4'b0010, "rd_pins", int'(p_pins), 4'b0010);
                        chk(O_wb_dat == m_ce.dat, "rd_dat", int'(O_wb_dat), int'(m_ce.dat));
                    end
                end
            end
        end
        p_pins = pins_now;
        p_adr  = O_sram_adr;
        p_sdat = O_sram_dat;
    end

    // ---------------- stimulus ----------------
    bit m_active = 1'b0;
    bit m_ack    = 1'b0;
    int m_t      = 0;

    task automatic tick();
        @(negedge I_clk);
        m_ack = O_wb_ack;
        @(posedge I_clk);
        #1;
    endtask

    task automatic set_vga(input bit r, input logic [AW-1:0] a);
        vga_exp_t e;
        vga_hist[cyc] = r;
        I_vga_req = r;
        I_vga_adr = a;
        if (r) begin
            e.adr = a;
            e.dat = ref_byte(a);
            vga_q.push_back(e);
        end
    endtask

    task automatic master_step();
        if (m_active && m_ack) begin
            m_active = 1'b0;
            I_wb_stb = 1'b0;
        end else if (m_active && (cyc - m_t) > 200) begin
            chk(1'b0, "ack_timeout", cyc - m_t, 200);
            cpu_q.delete();
            m_active = 1'b0;
            I_wb_stb = 1'b0;
        end
    endtask

    task automatic cpu_start(input bit we, input logic [AW-1:0] a, input logic [7:0] d);
        cpu_txn_t t;
        t.t = cyc; t.we = we; t.adr = a;
        if (we) begin
            t.dat = d;
            ref_mem[int'(a)] = d;
        end else begin
            t.dat = ref_byte(a);
        end
        cpu_q.push_back(t);
        m_active = 1'b1;
        m_t      = cyc;
        I_wb_stb = 1'b1;
        I_wb_we  = we;
        I_wb_adr = a;
        I_wb_dat = d;
    endtask

    // mode: 0 random VGA, 1 VGA every cycle, 2 every 2nd cycle, 3 none.
    // CPU writes stay below 0x40000 and VGA reads above it, so VGA data
    // never depends on a write's exact commit cycle.
    task automatic run(input int n, input int mode, input int pct);
        for (int i = 0; i < n; i++) begin
            bit v;
            bit we;
            master_step();
            case (mode)
                0:       v = 1'($urandom_range(1));
                1:       v = 1'b1;
                2:       v = (i % 2) == 0;
                default: v = 1'b0;
            endcase
            set_vga(v, {1'b1, 18'($urandom)});
            if (!m_active && int'($urandom_range(99)) < pct) begin
                we = 1'($urandom_range(1));
                cpu_start(we, we ? {1'b0, 18'($urandom)} : 19'($urandom), 8'($urandom));
            end
            tick();
        end
    endtask

    int r_cyc, got;

    initial begin
        #2 I_reset_n = 1'b0;
        repeat (2) @(negedge I_clk);
        chk({O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_dat_oe} == 4'b1110, "rst_pins",
            int'({O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_dat_oe}), 4'b1110);
        chk(O_wb_ack == 1'b0, "rst_ack", int'(O_wb_ack), 0);
        chk(O_sram_adr == '0, "rst_adr", int'(O_sram_adr), 0);
        chk(O_sram_dat == 8'h00, "rst_sdat", int'(O_sram_dat), 0);
        chk(O_wb_dat == 8'h00, "rst_wbdat", int'(O_wb_dat), 0);
        chk(O_vga_dat == 8'h00, "rst_vgadat", int'(O_vga_dat), 0);
        @(posedge I_clk);
        #3 I_reset_n = 1'b1;
        @(posedge I_clk);
        #1 mon_en = 1'b1;

        // Idle CPU read, then a write
        master_step(); set_vga(1'b0, '0); cpu_start(1'b0, 19'h20000, 8'h00); tick();
        run(4, 3, 0);
        master_step(); set_vga(1'b0, '0); cpu_start(1'b1, 19'h00123, 8'h5A); tick();
        run(4, 3, 0);
        // Simultaneous VGA and CPU requests
        master_step(); set_vga(1'b1, 19'h40000); cpu_start(1'b0, 19'h40001, 8'h00); tick();
        run(5, 3, 0);
        // VGA burst of 8 starving the CPU
        master_step(); set_vga(1'b1, 19'h4ABCD); cpu_start(1'b0, 19'h00123, 8'h00); tick();
        run(7, 1, 0);
        run(4, 3, 0);
        // Graphics-mode interleave with a continuously busy CPU
        run(24, 2, 100);
        run(4, 3, 0);

        // Reset in the middle of a CPU write slot
        mon_en   = 1'b0;
        I_wb_stb = 1'b1; I_wb_we = 1'b1; I_wb_adr = 19'h00456; I_wb_dat = 8'h77;
        tick();
        chk(O_sram_we_n == 1'b0 && O_sram_dat_oe == 1'b1, "rst_pre_wr",
            int'({O_sram_we_n, O_sram_dat_oe}), 2'b01);
        #2 I_reset_n = 1'b0;
        #1;
        chk({O_sram_ce_n, O_sram_we_n, O_sram_dat_oe} == 3'b110, "rst_async",
            int'({O_sram_ce_n, O_sram_we_n, O_sram_dat_oe}), 3'b110);
        @(negedge I_clk);
        chk(O_wb_ack == 1'b0, "rst_no_ack", int'(O_wb_ack), 0);
        @(posedge I_clk);
        @(negedge I_clk);
        chk(O_wb_ack == 1'b0, "rst_no_ack2", int'(O_wb_ack), 0);
        #1 I_reset_n = 1'b1;
        r_cyc = cyc;
        got   = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge I_clk);
            if (O_wb_ack) begin
                got = cyc;
                break;
            end
        end
        chk(got == r_cyc + 2, "rst_reserve_ack", got, r_cyc + 2);
        chk(sram_wr[19'h00456] && sram_wdat[19'h00456] == 8'h77, "rst_reserve_mem",
            int'(sram_wdat[19'h00456]), 8'h77);
        @(posedge I_clk);
        #1;
        I_wb_stb = 1'b0;
        ref_mem[int'(19'h00456)] = 8'h77;
        mon_en = 1'b1;

        // Randomized traffic
        run(600, 0, 60);
        run(150, 2, 80);
        run(8, 3, 0);
        chk(!m_active, "cpu_drain", int'(m_active), 0);
        chk(cpu_q.size() == 0, "cpu_queue_empty", cpu_q.size(), 0);
        chk(vga_q.size() == 0, "vga_queue_empty", vga_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_wb8.md
Name: sram_arbiter_wb8

Overview:
- Single-port arbiter for the board's 512 KiB x 8 asynchronous SRAM. The SRAM is shared between the VGA scan-out fetcher and the CPU's 8-bit Wishbone data bus.
- VGA fetches have absolute priority and a fixed one-cycle latency, so scan-out timing never changes.
- CPU accesses fill the cycles the VGA leaves free; the CPU is stalled via delayed ack.
- Sits between the VGA controller, the Wishbone interconnect and the SRAM I/O pads. Pad tri-state is handled outside via O_sram_dat_oe.

Parameters:
ADR_WIDTH, 19, SRAM/CPU/VGA byte address width

Ports:
I_clk  in  1  system clock; VGA and Wishbone share it
I_reset_n  in  1  asynchronous active-low reset
I_vga_req  in  1  VGA read request, one-cycle pulse
I_vga_adr  in  ADR_WIDTH  VGA read address, valid with I_vga_req
O_vga_dat  out  8  VGA read data
I_wb_adr  in  ADR_WIDTH  CPU byte address
I_wb_dat  in  8  CPU write data
I_wb_stb  in  1  CPU strobe, held until ack
I_wb_we  in  1  CPU write enable
O_wb_ack  out  1  CPU ack, one-cycle pulse
O_wb_dat  out  8  CPU read data, valid with ack
O_sram_adr  out  ADR_WIDTH  SRAM address
O_sram_dat  out  8  SRAM write data
O_sram_dat_oe  out  1  pad output enable for write data
I_sram_dat  in  8  SRAM read data from pads
O_sram_ce_n  out  1  chip enable, active low
O_sram_oe_n  out  1  output enable, active low
O_sram_we_n  out  1  write enable, active low

Behaviour:
- Reset (async, I_reset_n=0), any cycle including mid-access:
  - slot=IDLE.
  - O_sram_ce_n=O_sram_oe_n=O_sram_we_n=1, O_sram_dat_oe=0, O_wb_ack=0.
  - O_sram_adr=0, O_sram_dat=0, O_wb_dat=0, O_vga_dat register=0.
  - An in-flight CPU access is dropped (no ack); the master re-issues.
- Slot FSM: states IDLE, VGA_RD, CPU_RD, CPU_WR. Every slot lasts exactly one cycle; all SRAM pin outputs are registered.
- Next-slot decision at each edge, evaluated from the cycle just ending (t):
  - I_vga_req=1 -> VGA_RD, with O_sram_adr<=I_vga_adr.
  - Else if cpu_pending (I_wb_stb=1, no ack high in t, no CPU slot in t) -> CPU_RD or CPU_WR per I_wb_we, with O_sram_adr<=I_wb_adr and O_sram_dat<=I_wb_dat.
  - Else -> IDLE.
- Pins per slot:
  - VGA_RD / CPU_RD: ce_n=0, oe_n=0, we_n=1, dat_oe=0.
  - CPU_WR: ce_n=0, oe_n=1, we_n=0, dat_oe=1.
  - IDLE: all inactive, dat_oe=0; address holds its last value.
- VGA timing: request in cycle t -> address on pins in t+1. In t+1, O_vga_dat = I_sram_dat (combinational pass-through) and is captured at the end of t+1. Outside VGA_RD, O_vga_dat holds the captured value.
- CPU timing, with no contention: stb seen in t -> slot in t+1 -> O_wb_ack=1 in t+2. For reads, O_wb_dat is captured from I_sram_dat at the end of the CPU_RD slot and held until the next CPU read.
- Contention: each cycle with I_vga_req=1 delays a pending CPU access by one cycle. Back-to-back VGA requests every cycle are legal and starve the CPU indefinitely; there is no timeout.
- CPU slot is committed once entered. A VGA request during the CPU slot gets the following slot; VGA latency is unaffected.
- Ack: a single-cycle pulse. During the ack cycle, I_wb_stb is ignored, so a master dropping stb one cycle late never double-issues. A VGA slot may coincide with the ack cycle.
- Turnaround: write data is released (dat_oe=0) on the same edge a following read slot asserts oe_n=0. This is acceptable at the system clock rate.
- Width: addresses pass through unmodified; no wrap or translation.

Test Plan:
- Idle CPU read: SRAM model byte[0x20000]=0xA5, stb/we=0 in cycle 0 -> pins adr=0x20000, oe_n=0 in cycle 1; ack=1 with O_wb_dat=0xA5 in cycle 2; ack=0 in cycle 3 even with stb still high.
- CPU write: stb/we=1, adr=0x00123, dat=0x5A -> cycle 1 shows we_n=0, dat_oe=1, O_sram_dat=0x5A; ack in cycle 2; model byte[0x123]=0x5A.
- Simultaneous requests in cycle 0: VGA adr=0x40000 (byte 0x11) and CPU read adr=0x40001 (byte 0x22):
  - cycle 1: VGA_RD, O_vga_dat=0x11.
  - cycle 2: CPU_RD.
  - cycle 3: ack with 0x22.
  - O_vga_dat stays 0x11 throughout.
- VGA every cycle for 8 cycles with CPU stb high: no CPU slot and no ack during the burst; CPU slot in the first cycle after the burst, ack one cycle later; every VGA datum arrives in its t+1 cycle.
- Reset mid-access: assert I_reset_n=0 asynchronously during a CPU_WR slot -> we_n=1 and dat_oe=0 immediately; no ack; after release, the pending stb is served normally.
- Interleave at graphics-mode spacing (VGA every 2nd cycle, CPU stb continuous): the CPU receives one access per 4 cycles (slot, ack, wait, re-sample); VGA data are all correct.
